// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, performs the
// access after LATENCY cycles and returns a single-cycle response pulse.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                accept;

  logic                wr_p0;
  logic                in_range_p0;
  logic [ADDR_W-1:0]   idx_p0;
  logic [DATA_W-1:0]   wdata_p0;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   done_rdata;
  logic                done_err;
  logic [DATA_W-1:0]   rdata_hold;
  logic                err_hold;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? DONE : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= 4'(cnt - 4'd1);
    end
  end

  // Request capture: fields frozen at acceptance, later req_* activity ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0       <= req_wr;
      in_range_p0 <= ((req_addr >> ADDR_W) == 16'd0);
      idx_p0      <= req_addr[ADDR_W-1:0];
      wdata_p0    <= req_wdata;
    end
  end

  // Access stage: the write lands at the end of DONE, so a later read sees it
  always_ff @(posedge clk) begin
    if (state == DONE && wr_p0 && in_range_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold <= '0;
      err_hold   <= 1'b0;
    end else if (state == DONE) begin
      rdata_hold <= done_rdata;
      err_hold   <= done_err;
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    done_err   = !in_range_p0;
    done_rdata = '0;
    if (!wr_p0 && in_range_p0) begin
      done_rdata = mem[idx_p0];
    end
    resp_rdata = resp_valid ? done_rdata : rdata_hold;
    resp_err   = resp_valid ? done_err   : err_hold;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 3 and 1), each checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_err;
  logic [15:0] resp_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 3 : 1;

    dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wr     (req_wr[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );

    // Model: busy_left counts the remaining not-ready cycles of the current
    // transaction; the final one of them is the response cycle.
    int          busy_left = 0;
    logic        p_wr = 1'b0;
    logic [15:0] p_addr = 16'h0;
    logic [15:0] p_wdata = 16'h0;
    logic [15:0] mem_m [DEPTH];
    logic [15:0] hold_rdata = 16'h0;
    logic        hold_err = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        busy_left = 0;
      end else if (busy_left > 0) begin
        if (busy_left == 1 && p_wr && p_addr < DEPTH) mem_m[p_addr[7:0]] = p_wdata;
        busy_left--;
      end else if (req_valid[g]) begin
        p_wr      = req_wr[g];
        p_addr    = req_addr[g];
        p_wdata   = req_wdata[g];
        busy_left = LAT;
      end
    end

    always @(negedge clk) begin
      logic in_r;
      if (rst) begin
        hold_rdata = 16'h0;
        hold_err   = 1'b0;
        chk("ready_in_reset", 32'(req_ready[g]), 32'd1);
        chk("valid_in_reset", 32'(resp_valid[g]), 32'd0);
      end else begin
        chk("ready", 32'(req_ready[g]), 32'(busy_left == 0));
        chk("resp_valid", 32'(resp_valid[g]), 32'(busy_left == 1));
        if (busy_left == 1) begin
          in_r       = (p_addr < DEPTH);
          hold_err   = !in_r;
          hold_rdata = (!p_wr && in_r) ? mem_m[p_addr[7:0]] : 16'h0;
        end
      end
      chk("resp_rdata", 32'(resp_rdata[g]), 32'(hold_rdata));
      chk("resp_err", 32'(resp_err[g]), 32'(hold_err));
    end
  end

  // One request on instance i; called and returning just after a falling edge.
  task automatic xact(input int i, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit scramble,
                      output logic [15:0] rd, output logic er, output int lat);
    int t;
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
    t = 0;
    while (!req_ready[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_seen", 32'(req_ready[i]), 32'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!resp_valid[i] && lat < 50) begin
      if (scramble) begin
        req_addr[i]  = 16'($urandom);
        req_wdata[i] = 16'($urandom);
        req_wr[i]    = 1'($urandom);
        req_valid[i] = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", 32'(resp_valid[i]), 32'd1);
    rd = resp_rdata[i];
    er = resp_err[i];
    req_valid[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, low, pulses;
    logic [15:0] last_rd;

    rst       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k]  = 16'h0;
      req_wdata[k] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(req_ready[k]), 32'd1);
      chk("reset_valid", 32'(resp_valid[k]), 32'd0);
      chk("reset_rdata", 32'(resp_rdata[k]), 32'h0);
      chk("reset_err", 32'(resp_err[k]), 32'd0);
    end
    #2 rst = 1'b0;
    @(negedge clk);

    // Read after write, LATENCY 3
    xact(0, 1'b1, 16'h0000, 16'h5A5A, 1'b0, rd, er, lat);
    xact(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, rd, er, lat);
    chk("wr5_latency", 32'(lat), 32'd3);
    chk("wr5_rdata", 32'(rd), 32'h0);
    chk("wr5_err", 32'(er), 32'd0);
    xact(0, 1'b0, 16'h0005, 16'h0000, 1'b0, rd, er, lat);
    chk("rd5_latency", 32'(lat), 32'd3);
    chk("rd5_rdata", 32'(rd), 32'hBEEF);
    chk("rd5_err", 32'(er), 32'd0);

    // Backpressure with req_valid held high across two reads
    xact(0, 1'b1, 16'h0001, 16'h0101, 1'b0, rd, er, lat);
    xact(0, 1'b1, 16'h0002, 16'h0202, 1'b0, rd, er, lat);
    req_wr[0]    = 1'b0;
    req_addr[0]  = 16'h0001;
    req_valid[0] = 1'b1;
    chk("bp_first_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_addr[0] = 16'h0002;
    low = 0;
    pulses = 0;
    while (!req_ready[0] && low < 50) begin
      if (resp_valid[0]) begin
        pulses++;
        last_rd = resp_rdata[0];
      end
      @(negedge clk);
      low++;
    end
    chk("bp_low_cycles_1", 32'(low), 32'd3);
    chk("bp_rdata_1", 32'(last_rd), 32'h0101);
    @(negedge clk);
    req_valid[0] = 1'b0;
    low = 0;
    while (!req_ready[0] && low < 50) begin
      if (resp_valid[0]) begin
        pulses++;
        last_rd = resp_rdata[0];
      end
      @(negedge clk);
      low++;
    end
    chk("bp_low_cycles_2", 32'(low - 1), 32'd2);
    chk("bp_pulses", 32'(pulses), 32'd2);
    chk("bp_rdata_2", 32'(last_rd), 32'h0202);

    // Out-of-range accesses
    xact(0, 1'b0, 16'h0100, 16'h0000, 1'b0, rd, er, lat);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_rdata", 32'(rd), 32'h0);
    xact(0, 1'b1, 16'h0100, 16'h1234, 1'b0, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1);
    xact(0, 1'b0, 16'h0000, 16'h0000, 1'b0, rd, er, lat);
    chk("no_alias_rdata", 32'(rd), 32'h5A5A);
    chk("no_alias_err", 32'(er), 32'd0);

    // Reset during the WAIT phase of a write
    xact(0, 1'b1, 16'h0003, 16'h1111, 1'b0, rd, er, lat);
    req_wr[0]    = 1'b1;
    req_addr[0]  = 16'h0003;
    req_wdata[0] = 16'h2222;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst_valid", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    xact(0, 1'b0, 16'h0003, 16'h0000, 1'b0, rd, er, lat);
    chk("midrst_rdata", 32'(rd), 32'h1111);

    // Input churn while busy
    xact(0, 1'b1, 16'h0007, 16'hCAFE, 1'b1, rd, er, lat);
    xact(0, 1'b0, 16'h0007, 16'h0000, 1'b1, rd, er, lat);
    chk("churn_rdata", 32'(rd), 32'hCAFE);
    chk("churn_latency", 32'(lat), 32'd3);

    // Minimum latency instance
    xact(1, 1'b1, 16'h00FF, 16'hA5A5, 1'b0, rd, er, lat);
    chk("l1_wr_latency", 32'(lat), 32'd1);
    chk("l1_wr_err", 32'(er), 32'd0);
    xact(1, 1'b0, 16'h00FF, 16'h0000, 1'b0, rd, er, lat);
    chk("l1_rd_latency", 32'(lat), 32'd1);
    chk("l1_rd_rdata", 32'(rd), 32'hA5A5);
    xact(1, 1'b0, 16'h8000, 16'h0000, 1'b0, rd, er, lat);
    chk("l1_oor_err", 32'(er), 32'd1);
    chk("l1_oor_rdata", 32'(rd), 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
